sprite_rom_arbiter: RTL and testbench

//  Shares one synchronous sprite/palette-index ROM port among NUM_REQ pixel requesters
//  (tank, battery, bullet renderers) in the vga_clk domain. Round-robin, one grant per cycle.

---
 rtl/sprite_arb_pkg.sv | 19 +
 rtl/sprite_arb_rr_pick.sv | 26 ++
 rtl/sprite_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite ROM arbiter: default sizes, requester ID type, slot names.
package sprite_arb_pkg;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_ADDR_W   = 11;
    localparam int unsigned DEF_DATA_W   = 4;
    localparam int unsigned DEF_ROM_LAT  = 1;
    localparam int unsigned DEF_LOCK_MAX = 16;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

    typedef enum req_id_t {
        REQ_TANK0   = 2'd0,
        REQ_TANK1   = 2'd1,
        REQ_BATTERY = 2'd2,
        REQ_BULLET  = 2'd3
    } req_slot_e;

endpackage

// File: rtl/sprite_arb_rr_pick.sv
// Rotating find-first: scans req starting at ptr, wrapping mod NUM_REQ; first set bit wins.
module sprite_arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        any    = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!any && req[ID_W'(idx)]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port, with ID-tagged read return.
// Optional burst locking enabled by defining SPRITE_ARB_LOCK_EN.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ROM_LAT  = DEF_ROM_LAT,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef SPRITE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   adv_ptr;
    logic [ADDR_W-1:0] last_addr;
    logic              any;
    logic [ID_W-1:0]   winner;
    logic              vld_pipe [ROM_LAT];
    logic [ID_W-1:0]   id_pipe  [ROM_LAT];

    sprite_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    // Grant decode and address mux; idle cycles hold the previous address.
    always_comb begin
        gnt         = '0;
        rom_address = last_addr;
        if (any) begin
            gnt[winner] = 1'b1;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (winner == ID_W'(i)) begin
                    rom_address = req_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    assign adv_ptr = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);

`ifdef SPRITE_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_run;
    logic [ID_W-1:0]  lock_id;

    // Length of the locked run including this cycle's grant.
    assign lock_run = (lock_cnt != '0 && lock_id == winner) ? lock_cnt + CNT_W'(1) : CNT_W'(1);

    // A locked winner parks ptr on itself so it wins again; the run is capped at LOCK_MAX.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            lock_cnt <= '0;
            lock_id  <= '0;
        end else if (any) begin
            lock_id <= winner;
            if (req_lock[winner] && (32'(lock_run) < LOCK_MAX)) begin
                ptr      <= winner;
                lock_cnt <= lock_run;
            end else begin
                ptr      <= adv_ptr;
                lock_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= adv_ptr;
        end
    end
`endif

    // Address history and the {valid,id} return pipeline matching ROM latency.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            last_addr <= '0;
            for (int unsigned k = 0; k < ROM_LAT; k++) begin
                vld_pipe[k] <= 1'b0;
                id_pipe[k]  <= '0;
            end
        end else begin
            last_addr   <= rom_address;
            vld_pipe[0] <= any;
            id_pipe[0]  <= winner;
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
        end
    end

    assign rd_valid = vld_pipe[ROM_LAT-1];
    assign rd_id    = id_pipe[ROM_LAT-1];
    assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (default NUM_REQ=4, ROM_LAT=1); lock run checked when SPRITE_ARB_LOCK_EN is defined.
module tb_sprite_rom_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ID_W    = 2;

    logic                      vga_clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
`ifdef SPRITE_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rd_valid;
    logic [ID_W-1:0]           rd_id;
    logic [DATA_W-1:0]         rd_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] addrs [NUM_REQ];

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
`ifdef SPRITE_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data)
    );

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return DATA_W'(a ^ (a >> 4) ^ (a >> 8));
    endfunction

    // Behavioural one-cycle synchronous ROM.
    always @(posedge vga_clk) rom_q <= rom_f(rom_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_addrs();
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addrs[i];
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        req_addr = '0;
`ifdef SPRITE_ARB_LOCK_EN
        req_lock = '0;
`endif
        addrs[0] = 11'h055; addrs[1] = 11'h2F0; addrs[2] = 11'h1A5; addrs[3] = 11'h3C0;
        load_addrs();
        repeat (2) @(negedge vga_clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_addr", 32'(rom_address), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_id", 32'(rd_id), 32'h0);

        // single request from requester 2
        @(negedge vga_clk);
        reset = 1'b0;
        req   = 4'b0100;
        #1;
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_addr", 32'(rom_address), 32'h1A5);
        @(negedge vga_clk);
        check("single_valid", 32'(rd_valid), 32'h1);
        check("single_id", 32'(rd_id), 32'h2);
        check("single_data", 32'(rd_data), 32'(rom_f(11'h1A5)));
        req = 4'b0000;
        #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_hold_addr", 32'(rom_address), 32'h1A5);

        // ptr now 3: requester 3 first, then wrap to 0
        @(negedge vga_clk);
        check("idle_valid", 32'(rd_valid), 32'h0);
        req = 4'b1001;
        #1;
        check("wrap_gnt3", 32'(gnt), 32'h8);
        check("wrap_addr3", 32'(rom_address), 32'h3C0);
        @(negedge vga_clk);
        check("wrap_id3", 32'(rd_id), 32'h3);
        check("wrap_data3", 32'(rd_data), 32'(rom_f(11'h3C0)));
        #1;
        check("wrap_gnt0", 32'(gnt), 32'h1);
        check("wrap_addr0", 32'(rom_address), 32'h055);
        @(negedge vga_clk);
        check("wrap_id0", 32'(rd_id), 32'h0);
        req = 4'b0000;
        #1;
        check("wrap_idle_addr", 32'(rom_address), 32'h055);
        @(negedge vga_clk);
        check("wrap_idle_valid", 32'(rd_valid), 32'h0);
        check("wrap_idle_addr2", 32'(rom_address), 32'h055);
        req = 4'b1111;
        #1;
        check("ptr_held_gnt", 32'(gnt), 32'h2);

        // let the pipeline fill, then reset mid-traffic
        repeat (3) @(negedge vga_clk);
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        check("midrst_valid", 32'(rd_valid), 32'h0);
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_addr", 32'(rom_address), 32'h0);
        check("midrst_id", 32'(rd_id), 32'h0);

        // all requesters held 8 cycles: rotation from ptr 0
        @(negedge vga_clk);
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                check("rr_valid", 32'(rd_valid), 32'h1);
                check("rr_id", 32'(rd_id), 32'((k - 1) % 4));
                check("rr_data", 32'(rd_data), 32'(rom_f(addrs[(k - 1) % 4])));
            end else begin
                check("rr_first_valid", 32'(rd_valid), 32'h0);
            end
            #1;
            check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            check("rr_addr", 32'(rom_address), 32'(addrs[k % 4]));
            @(negedge vga_clk);
        end
        check("rr_last_id", 32'(rd_id), 32'h3);

        // withdraw: requester 1 asks for one cycle while 0 wins, then drops
        req = 4'b0011;
        #1;
        check("wd_gnt_a", 32'(gnt), 32'h1);
        @(negedge vga_clk);
        check("wd_id_a", 32'(rd_id), 32'h0);
        req = 4'b0001;
        #1;
        check("wd_gnt_b", 32'(gnt), 32'h1);
        @(negedge vga_clk);
        check("wd_id_b", 32'(rd_id), 32'h0);
        check("wd_valid_b", 32'(rd_valid), 32'h1);
        req = 4'b0000;
        #1;
        check("wd_gnt_c", 32'(gnt), 32'h0);
        @(negedge vga_clk);
        check("wd_valid_c", 32'(rd_valid), 32'h0);

`ifdef SPRITE_ARB_LOCK_EN
        // ptr is 1: requester 1 locks and keeps the port for 16 grants
        req      = 4'b1111;
        req_lock = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("lock_gnt", 32'(gnt), 32'h2);
            @(negedge vga_clk);
        end
        #1;
        check("lock_release_gnt", 32'(gnt), 32'h4);
        @(negedge vga_clk);
        req      = 4'b0000;
        req_lock = 4'b0000;
        @(negedge vga_clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
